branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
Dynamic branch prediction and resolution unit for the pipelined RV32I core. It provides a fetch-stage prediction from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves branches and jumps in execute using the ALU flags zero, lt and ltu, and issues a registered redirect/flush one cycle after a misprediction. It supersedes the purely combinational taken/not-taken decision.

Parameters:
PC_W, 32, PC/target width in bits
IDX_W, 6, BTB index width; 2^IDX_W entries, index = pc[IDX_W+1:2]
TAG_W, 8, tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; requires IDX_W+TAG_W+2 <= PC_W
DYN_EN, 1, 1 = dynamic prediction; 0 = static not-taken (tables still updated, pred_taken forced 0)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
f_pc  in  PC_W  fetch PC
f_pred_taken  out  1  prediction for f_pc (combinational)
f_pred_target  out  PC_W  predicted target (combinational)
ex_valid  in  1  execute-stage instruction valid
ex_pc  in  PC_W  execute-stage PC
ex_opcode  in  7  execute-stage opcode
ex_func3  in  3  execute-stage func3
ex_zero  in  1  ALU equal flag
ex_lt  in  1  ALU signed less-than
ex_ltu  in  1  ALU unsigned less-than
ex_target  in  PC_W  computed branch/jump target
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_target  in  PC_W  predicted target carried down the pipe
ex_taken  out  1  resolved taken (combinational)
redirect  out  1  registered flush/redirect pulse
redirect_pc  out  PC_W  registered correct next PC

Behaviour:
- Reset is asynchronous: all valid bits 0, all counters 2'b01 (weak not-taken), redirect 0, redirect_pc 0. Reset during a pending redirect drops it.
- Lookup: hit = valid[idx] && tag[idx]==tag(f_pc). f_pred_taken = DYN_EN && hit && ctr[idx][1]. f_pred_target = target[idx], or 0 when there is no hit.
- Control classification: JAL 1101111, JALR 1100111, BRANCH 1100011. All other opcodes are non-control.
- Resolution, when ex_valid is set:
  - JAL/JALR: always taken.
  - BRANCH: BEQ 000 zero; BNE 001 !zero; BLT 100 lt; BGE 101 !lt; BLTU 110 ltu; BGEU 111 !ltu.
  - BRANCH with func3 010/011: not taken, table not updated.
  - Non-control or !ex_valid: ex_taken = 0.
- Mispredict, for a control instruction with ex_valid set: (ex_taken != ex_pred_taken) OR (ex_taken && ex_pred_target != ex_target). Non-control instructions with ex_pred_taken=1 are also a mispredict, with redirect_pc = ex_pc+4.
- Redirect latency: on the clock edge after the mispredict, redirect=1 for exactly one cycle. redirect_pc = ex_taken ? ex_target : ex_pc+4, with the +4 wrapping modulo 2^PC_W.
- Table update on the same clock edge, for valid control instructions only (not illegal func3):
  - Write tag and set valid.
  - Write target when taken.
  - Counter: +1 if taken, saturating at 11; -1 if not taken, saturating at 00.
  - JAL/JALR force the counter to 11.
  - On a tag miss, a taken allocation initialises the counter to 10; a not-taken allocation initialises it to 01.
- Simultaneous fetch read and execute write to the same index: fetch sees the pre-update value.
- Back-to-back mispredicts: each produces its own one-cycle redirect, and the later one overwrites redirect_pc. The pipeline is responsible for squashing ex_valid behind a redirect.

Optional Feature:
BPU_PERF_CNT_EN:
- When defined, adds outputs perf_branches[31:0] and perf_mispredicts[31:0].
- perf_branches increments on every valid resolved control instruction.
- perf_mispredicts increments on every redirect.
- Both counters reset to 0 and wrap at 2^32.
- When not defined, these ports and the counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0, f_pred_target=0, redirect=0.
- BEQ at 0x100, zero=1, ex_target=0x140, ex_pred_taken=0 -> ex_taken=1; next cycle redirect=1, redirect_pc=0x140; afterwards f_pc=0x100 gives f_pred_taken=1, f_pred_target=0x140.
- Same BNE resolved not-taken 3 times after the counter reaches 11 -> counter goes 10, 01, 00; f_pred_taken=0 after the second update; counter stays 00 on further not-taken.
- BGEU with ltu=1, pred_taken=1 -> ex_taken=0, redirect_pc=ex_pc+4; func3=010 with pred 0 -> no redirect, table unchanged.
- JALR at 0x200, target 0x380, pred target 0x300 with pred_taken=1 -> redirect_pc=0x380, counter 11; ex_pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x0.
- Assert rst the cycle after a mispredict -> redirect never rises, and all lookups miss. With BPU_PERF_CNT_EN, 5 branches including 2 mispredicts -> perf_branches=5, perf_mispredicts=2.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup and execute resolution signals of the branch predict unit
interface branch_predict_unit_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] f_pc;
  logic            f_pred_taken;
  logic [PC_W-1:0] f_pred_target;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_func3;
  logic            ex_zero;
  logic            ex_lt;
  logic            ex_ltu;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            ex_taken;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output f_pc, ex_valid, ex_pc, ex_opcode, ex_func3, ex_zero, ex_lt, ex_ltu,
           ex_target, ex_pred_taken, ex_pred_target,
    input  f_pred_taken, f_pred_target, ex_taken, redirect, redirect_pc
  );

  modport slave (
    input  f_pc, ex_valid, ex_pc, ex_opcode, ex_func3, ex_zero, ex_lt, ex_ltu,
           ex_target, ex_pred_taken, ex_pred_target,
    output f_pred_taken, f_pred_target, ex_taken, redirect, redirect_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB with 2-bit counters, execute-stage branch resolution and registered redirect
// Optional performance counters enabled by defining BPU_PERF_CNT_EN.
module branch_predict_unit #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter bit DYN_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bus
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
`endif
);
  localparam int N = 1 << IDX_W;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [N-1:0]     r_valid;
  logic [TAG_W-1:0] r_tag    [N];
  logic [PC_W-1:0]  r_target [N];
  logic [1:0]       r_ctr    [N];
  logic             r_redirect;
  logic [PC_W-1:0]  r_redirect_pc;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_is_jump;
  logic             w_is_br;
  logic             w_cond;
  logic             w_br_legal;
  logic             w_taken;
  logic             w_mispredict;
  logic             w_upd;
  logic [PC_W-1:0]  w_next_pc;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_unused_ok;

  assign w_f_idx = bus.f_pc[IDX_W+1:2];
  assign w_f_tag = bus.f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  assign bus.f_pred_taken  = DYN_EN && w_f_hit && r_ctr[w_f_idx][1];
  assign bus.f_pred_target = w_f_hit ? r_target[w_f_idx] : '0;

  assign w_ex_idx  = bus.ex_pc[IDX_W+1:2];
  assign w_ex_tag  = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ctr_cur = r_ctr[w_ex_idx];

  assign w_is_jump = (bus.ex_opcode == OP_JAL) || (bus.ex_opcode == OP_JALR);
  assign w_is_br   = (bus.ex_opcode == OP_BRANCH);

  always_comb begin
    w_cond     = 1'b0;
    w_br_legal = 1'b1;
    case (bus.ex_func3)
      3'b000:  w_cond = bus.ex_zero;
      3'b001:  w_cond = !bus.ex_zero;
      3'b100:  w_cond = bus.ex_lt;
      3'b101:  w_cond = !bus.ex_lt;
      3'b110:  w_cond = bus.ex_ltu;
      3'b111:  w_cond = !bus.ex_ltu;
      default: w_br_legal = 1'b0;
    endcase
  end

  assign w_taken      = bus.ex_valid && (w_is_jump || (w_is_br && w_cond));
  assign bus.ex_taken = w_taken;

  // Non-control instructions predicted taken still need the pipeline steered back to pc+4.
  assign w_mispredict = bus.ex_valid &&
                        ((w_is_jump || w_is_br)
                          ? ((w_taken != bus.ex_pred_taken) ||
                             (w_taken && (bus.ex_pred_target != bus.ex_target)))
                          : bus.ex_pred_taken);

  assign w_upd     = bus.ex_valid && (w_is_jump || (w_is_br && w_br_legal));
  assign w_next_pc = w_taken ? bus.ex_target : (bus.ex_pc + PC_W'(4));

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_is_jump) begin
      w_ctr_next = 2'b11;
    end else if (!w_ex_hit) begin
      w_ctr_next = w_taken ? 2'b10 : 2'b01;
    end else if (w_taken) begin
      w_ctr_next = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'b01;
    end else begin
      w_ctr_next = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      for (int i = 0; i < N; i++) begin
        r_ctr[i] <= 2'b01;
      end
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= w_next_pc;
      end
      if (w_upd) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_ctr[w_ex_idx]   <= w_ctr_next;
      end
    end
  end

  // Tags and targets are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_upd) begin
      r_tag[w_ex_idx] <= w_ex_tag;
      if (w_taken) begin
        r_target[w_ex_idx] <= bus.ex_target;
      end
    end
  end

  assign bus.redirect    = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;
  assign w_unused_ok     = &{1'b0, bus.f_pc, bus.ex_pc};

`ifdef BPU_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_upd) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end
      if (w_mispredict) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`endif
endmodule
